rob_valid_tracker: RTL and testbench

Allocation and completion tracker for the reorder buffer. Hands out entry IDs in order, accepts out-of-order completion marks from WR_PORTS execution channels, and presents the oldest entry for in-order retirement through a valid/ready handshake. Sits between dispatch (allocate), the writeback ports (set) and the ROB commit stage (retire), and replaces the single-port flat valid bitmap.

---
 rtl/rob_valid_tracker_if.sv | 33 +++
 rtl/rob_valid_tracker.sv | 131 +++++++++++++
 tb/tb_rob_valid_tracker.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_valid_tracker_if.sv
// Bundle of dispatch, writeback, commit and lookup signals around the ROB valid tracker.
// The tracker connects through the slave modport; its environment drives the master side.
interface rob_valid_tracker_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int WR_PORTS   = 2
);
    logic                           flush_i;
    logic                           alloc_i;
    logic [ADDR_WIDTH-1:0]          alloc_id_o;
    logic                           full_o;
    logic                           empty_o;
    logic [ADDR_WIDTH:0]            cnt_o;
    logic [WR_PORTS-1:0]            set_i;
    logic [WR_PORTS*ADDR_WIDTH-1:0] set_addr_i;
    logic                           retire_valid_o;
    logic [ADDR_WIDTH-1:0]          retire_id_o;
    logic                           retire_ready_i;
    logic [ADDR_WIDTH-1:0]          addr_read_i;
    logic                           read_done_o;
    logic                           err_o;

    modport master (
        output flush_i, alloc_i, set_i, set_addr_i, retire_ready_i, addr_read_i,
        input  alloc_id_o, full_o, empty_o, cnt_o, retire_valid_o, retire_id_o,
               read_done_o, err_o
    );

    modport slave (
        input  flush_i, alloc_i, set_i, set_addr_i, retire_ready_i, addr_read_i,
        output alloc_id_o, full_o, empty_o, cnt_o, retire_valid_o, retire_id_o,
               read_done_o, err_o
    );
endinterface

// File: rtl/rob_valid_tracker.sv
// In-order allocate / out-of-order complete / in-order retire tracker for the reorder buffer.
// Optional protocol checker enabled by defining ROB_VALID_CHECK_EN; otherwise err_o is tied low.
module rob_valid_tracker #(
    parameter int ADDR_WIDTH = 4,
    parameter int WR_PORTS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rob_valid_tracker_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0]      alloc_reg, alloc_next;
    logic [DEPTH-1:0]      done_reg, done_next;
    logic [ADDR_WIDTH-1:0] head_reg, head_next;
    logic [ADDR_WIDTH-1:0] tail_reg, tail_next;
    logic [ADDR_WIDTH:0]   cnt_reg, cnt_next;

    logic [ADDR_WIDTH-1:0] port_addr [WR_PORTS];
    logic [DEPTH-1:0]      port_mask [WR_PORTS];
    logic [DEPTH-1:0]      set_mask;
    logic                  full;
    logic                  retire_valid;
    logic                  alloc_fire;
    logic                  retire_fire;

    // One-hot decode per completion port; ports are OR-merged below.
    genvar gi;
    generate
        for (gi = 0; gi < WR_PORTS; gi++) begin : g_port
            assign port_addr[gi] = bus.set_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign port_mask[gi] = bus.set_i[gi] ? (DEPTH'(1) << port_addr[gi]) : '0;
        end
    endgenerate

    always_comb begin
        set_mask = '0;
        for (int p = 0; p < WR_PORTS; p++) begin
            set_mask = set_mask | port_mask[p];
        end
    end

    assign full         = (cnt_reg == (ADDR_WIDTH+1)'(DEPTH));
    assign retire_valid = alloc_reg[head_reg] & done_reg[head_reg];
    assign alloc_fire   = bus.alloc_i & ~full;
    assign retire_fire  = retire_valid & bus.retire_ready_i;

    // Apply order set -> retire -> alloc so retire beats a set to the head, and a set
    // to the tail is dropped because alloc_reg[tail] is still clear.
    always_comb begin
        alloc_next = alloc_reg;
        done_next  = done_reg | (set_mask & alloc_reg);
        head_next  = head_reg;
        tail_next  = tail_reg;
        cnt_next   = cnt_reg + (ADDR_WIDTH+1)'(alloc_fire) - (ADDR_WIDTH+1)'(retire_fire);
        if (retire_fire) begin
            alloc_next[head_reg] = 1'b0;
            done_next[head_reg]  = 1'b0;
            head_next            = head_reg + ADDR_WIDTH'(1);
        end
        if (alloc_fire) begin
            alloc_next[tail_reg] = 1'b1;
            done_next[tail_reg]  = 1'b0;
            tail_next            = tail_reg + ADDR_WIDTH'(1);
        end
        if (bus.flush_i) begin
            alloc_next = '0;
            done_next  = '0;
            head_next  = '0;
            tail_next  = '0;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alloc_reg <= '0;
            done_reg  <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            alloc_reg <= alloc_next;
            done_reg  <= done_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.alloc_id_o     = tail_reg;
    assign bus.full_o         = full;
    assign bus.empty_o        = (cnt_reg == '0);
    assign bus.cnt_o          = cnt_reg;
    assign bus.retire_valid_o = retire_valid;
    assign bus.retire_id_o    = head_reg;
    assign bus.read_done_o    = done_reg[bus.addr_read_i];

`ifdef ROB_VALID_CHECK_EN
    logic err_reg, err_next;
    logic proto_err;

    // Flagged conditions are still handled exactly as in the unchecked build.
    always_comb begin
        proto_err = bus.alloc_i & full;
        for (int p = 0; p < WR_PORTS; p++) begin
            if (bus.set_i[p] && (!alloc_reg[port_addr[p]] || done_reg[port_addr[p]])) begin
                proto_err = 1'b1;
            end
            for (int q = p + 1; q < WR_PORTS; q++) begin
                if (bus.set_i[p] && bus.set_i[q] && (port_addr[p] == port_addr[q])) begin
                    proto_err = 1'b1;
                end
            end
        end
        err_next = err_reg | (proto_err & ~bus.flush_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign bus.err_o = err_reg;
`else
    assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_rob_valid_tracker.sv
// Directed bench for rob_valid_tracker: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them, and checks every retire handshake in order.
module tb_rob_valid_tracker;
    localparam int AW = 4;
    localparam int WP = 2;
`ifdef ROB_VALID_CHECK_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    localparam int F_CNT = 0, F_FULL = 1, F_EMPTY = 2, F_RV = 3, F_RID = 4,
                   F_AID = 5, F_RD = 6, F_ERR = 7;

    typedef struct {
        int    t;
        string name;
        int    f;
        int    v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tick = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sq[$];
    int   rq[$];
    exp_t mon_e;
    int   mon_act;
    int   mon_rid;

    rob_valid_tracker_if #(.ADDR_WIDTH(AW), .WR_PORTS(WP)) bus ();

    rob_valid_tracker #(.ADDR_WIDTH(AW), .WR_PORTS(WP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    function automatic int fld(input int f);
        case (f)
            F_CNT:   return int'(bus.cnt_o);
            F_FULL:  return int'(bus.full_o);
            F_EMPTY: return int'(bus.empty_o);
            F_RV:    return int'(bus.retire_valid_o);
            F_RID:   return int'(bus.retire_id_o);
            F_AID:   return int'(bus.alloc_id_o);
            F_RD:    return int'(bus.read_done_o);
            default: return int'(bus.err_o);
        endcase
    endfunction

    // Monitor: compares the expectations due this cycle and every honoured retire.
    always @(negedge clk) begin
        while (sq.size() > 0 && sq[0].t <= tick) begin
            mon_e   = sq.pop_front();
            mon_act = fld(mon_e.f);
            checks++;
            if (mon_e.t != tick || mon_act != mon_e.v) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d (tick %0d, due %0d)",
                         mon_e.name, mon_act, mon_e.v, tick, mon_e.t);
            end
        end
        if (rst_n && bus.retire_valid_o && bus.retire_ready_i && !bus.flush_i) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected: got id %0d, expected no retire", bus.retire_id_o);
            end else begin
                mon_rid = rq.pop_front();
                if (int'(bus.retire_id_o) != mon_rid) begin
                    errors++;
                    $display("FAIL retire_id: got %0d, expected %0d", bus.retire_id_o, mon_rid);
                end else begin
                    $display("retire id %0d at tick %0d", bus.retire_id_o, tick);
                end
            end
        end
    end

    task automatic chk(input string name, input int f, input int v);
        exp_t e;
        e.t = tick; e.name = name; e.f = f; e.v = v;
        sq.push_back(e);
    endtask

    task automatic drive(input bit al, input bit [1:0] st, input int a0, input int a1,
                         input bit rdy, input bit fl, input int ar);
        bus.alloc_i        = al;
        bus.set_i          = st;
        bus.set_addr_i     = {AW'(a1), AW'(a0)};
        bus.retire_ready_i = rdy;
        bus.flush_i        = fl;
        bus.addr_read_i    = AW'(ar);
    endtask

    task automatic idle(input bit rdy, input int ar);
        drive(1'b0, 2'b00, 0, 0, rdy, 1'b0, ar);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle(1'b0, 0);
        step; step;
        rst_n = 1'b1;

        // Reset state
        idle(1'b0, 0);
        chk("rst_cnt", F_CNT, 0);   chk("rst_full", F_FULL, 0); chk("rst_empty", F_EMPTY, 1);
        chk("rst_rv", F_RV, 0);     chk("rst_aid", F_AID, 0);   chk("rst_rid", F_RID, 0);
        chk("rst_rd", F_RD, 0);     chk("rst_err", F_ERR, 0);
        step;

        // Fill all 16 entries, then a refused 17th alloc
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0, 0);
            chk("fill_aid", F_AID, i); chk("fill_cnt", F_CNT, i);
            step;
        end
        drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0, 0);
        chk("full_cnt", F_CNT, 16); chk("full_flag", F_FULL, 1);
        chk("full_aid", F_AID, 0);  chk("full_empty", F_EMPTY, 0);
        step;
        idle(1'b0, 0);
        chk("over_cnt", F_CNT, 16); chk("over_aid", F_AID, 0);
        chk("over_full", F_FULL, 1); chk("over_rv", F_RV, 0);
        step;
        drive(1'b0, 2'b00, 0, 0, 1'b0, 1'b1, 0);
        step;
        idle(1'b0, 0);
        chk("fl1_empty", F_EMPTY, 1); chk("fl1_cnt", F_CNT, 0);
        step;

        // Out-of-order completion, in-order retire
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0, 0);
            step;
        end
        drive(1'b0, 2'b11, 2, 3, 1'b1, 1'b0, 3);
        chk("ooo_cnt", F_CNT, 4); chk("ooo_rd3_before", F_RD, 0);
        step;
        drive(1'b0, 2'b11, 0, 1, 1'b1, 1'b0, 3);
        chk("ooo_rd3_after", F_RD, 1); chk("ooo_rv_wait", F_RV, 0);
        step;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 0);
            chk("ooo_rv", F_RV, 1); chk("ooo_rid", F_RID, i);
            rq.push_back(i);
            step;
        end
        idle(1'b0, 0);
        chk("ooo_rv_end", F_RV, 0); chk("ooo_empty", F_EMPTY, 1);
        step;

        // Ready high on a not-done head; ready low holds retire_valid
        drive(1'b0, 2'b00, 0, 0, 1'b0, 1'b1, 0);
        step;
        drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0, 0);
        chk("hd_aid0", F_AID, 0);
        step;
        drive(1'b1, 2'b10, 0, 1, 1'b0, 1'b0, 0);
        chk("hd_aid1", F_AID, 1);
        step;
        for (int i = 0; i < 2; i++) begin
            idle(1'b1, 1);
            chk("hd_rv_idle", F_RV, 0); chk("hd_set_alloc_dropped", F_RD, 0); chk("hd_cnt", F_CNT, 2);
            step;
        end
        drive(1'b0, 2'b01, 0, 0, 1'b1, 1'b0, 0);
        chk("hd_rv_preset", F_RV, 0);
        step;
        drive(1'b0, 2'b10, 0, 1, 1'b1, 1'b0, 0);
        chk("hd_rv_set", F_RV, 1); chk("hd_rid0", F_RID, 0);
        rq.push_back(0);
        step;
        for (int i = 0; i < 5; i++) begin
            idle(1'b0, 1);
            chk("hold_rv", F_RV, 1); chk("hold_rid", F_RID, 1);
            chk("hold_rd", F_RD, 1); chk("hold_cnt", F_CNT, 1);
            step;
        end
        drive(1'b0, 2'b10, 0, 1, 1'b1, 1'b0, 1);
        chk("hold_rv_last", F_RV, 1);
        rq.push_back(1);
        step;
        idle(1'b0, 1);
        chk("retire_wins_rd", F_RD, 0); chk("retire_wins_rv", F_RV, 0);
        chk("retire_wins_empty", F_EMPTY, 1);
        step;

        // Full buffer: alloc + retire same cycle, then wrap
        drive(1'b0, 2'b00, 0, 0, 1'b0, 1'b1, 0);
        step;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, (i == 1) ? 2'b01 : 2'b00, 0, 0, 1'b0, 1'b0, 0);
            chk("wrap_fill_aid", F_AID, i);
            step;
        end
        drive(1'b1, 2'b00, 0, 0, 1'b1, 1'b0, 0);
        chk("wrap_full", F_FULL, 1); chk("wrap_rv", F_RV, 1); chk("wrap_rid", F_RID, 0);
        rq.push_back(0);
        step;
        drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0, 0);
        chk("wrap_cnt15", F_CNT, 15); chk("wrap_nfull", F_FULL, 0); chk("wrap_aid0", F_AID, 0);
        step;
        idle(1'b0, 0);
        chk("wrap_cnt16", F_CNT, 16); chk("wrap_full2", F_FULL, 1);
        chk("wrap_aid1", F_AID, 1);   chk("wrap_rid1", F_RID, 1);
        step;

        // Flush with activity in the same cycle
        drive(1'b0, 2'b00, 0, 0, 1'b0, 1'b1, 0);
        step;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'b00, 0, 0, 1'b0, 1'b0, 0);
            step;
        end
        drive(1'b0, 2'b11, 0, 2, 1'b0, 1'b0, 2);
        step;
        idle(1'b0, 2);
        chk("pre_fl_rd2", F_RD, 1); chk("pre_fl_rv", F_RV, 1); chk("pre_fl_cnt", F_CNT, 6);
        step;
        drive(1'b1, 2'b11, 3, 4, 1'b1, 1'b1, 2);
        step;
        idle(1'b0, 0);
        chk("fl_empty", F_EMPTY, 1); chk("fl_cnt", F_CNT, 0); chk("fl_rv", F_RV, 0);
        chk("fl_rid", F_RID, 0);     chk("fl_aid", F_AID, 0);
        step;
        for (int i = 0; i < 16; i++) begin
            idle(1'b0, i);
            chk("fl_rd", F_RD, 0);
            step;
        end

        // Error flag: set to unallocated entry, sticky through flush, cleared by reset
        rst_n = 1'b0;
        idle(1'b0, 0);
        step;
        rst_n = 1'b1;
        drive(1'b0, 2'b01, 7, 0, 1'b0, 1'b0, 7);
        chk("err_pre", F_ERR, 0);
        step;
        idle(1'b0, 7);
        chk("err_set_unalloc", F_ERR, ERR_EXP); chk("unalloc_rd7", F_RD, 0);
        step;
        drive(1'b0, 2'b00, 0, 0, 1'b0, 1'b1, 0);
        step;
        idle(1'b0, 0);
        chk("err_after_flush", F_ERR, ERR_EXP);
        step;
        rst_n = 1'b0;
        idle(1'b0, 0);
        step;
        rst_n = 1'b1;
        idle(1'b0, 0);
        chk("err_after_rst", F_ERR, 0); chk("cnt_after_rst", F_CNT, 0);
        step;

        @(negedge clk);
        #1;
        checks++;
        if (sq.size() != 0) begin
            errors++;
            $display("FAIL expect_drain: got %0d pending, expected 0", sq.size());
        end
        checks++;
        if (rq.size() != 0) begin
            errors++;
            $display("FAIL retire_drain: got %0d missing retires, expected 0", rq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
